nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//   Sequencer that reuses a single 4-bit carry-lookahead slice to add or subtract WIDTH-bit operands.
//   Processes one nibble per clock, LSB first, holding the carry in a register between nibbles.
//   Uses valid/ready handshakes on both sides; sits between operand producers and result consumers
//   in area-constrained datapaths.
// PARAMETERS
//   WIDTH  16  operand/result width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
//   (derived) NIBBLES = WIDTH/4; CNT_W = max(1,$clog2(NIBBLES))
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand request valid
//   in_ready   out  1      controller can accept an operand set
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add mode only)
//   sub        in   1      1: compute a - b (b inverted, initial carry forced to 1, cin ignored)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB nibble (for sub: 1 = no borrow)
//   ovf        out  1      two's-complement overflow
// BEHAVIOUR
//   - Reset (async assert, sync-safe release): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0,
//     ovf=0, nibble index=0, carry reg=0. Reset mid-RUN or mid-DONE aborts; no result is emitted.
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: in_ready=1. On in_valid&&in_ready at an edge: latch a, b_eff = sub ? ~b : b,
//       carry = sub ? 1 : cin, idx=0, go to RUN.
//     RUN: in_ready=0. Each edge: sum[4*idx+:4] <= slice sum of a[4*idx+:4], b_eff[4*idx+:4], carry;
//       carry <= slice cout; idx++. On the edge where idx==NIBBLES-1: cout <= slice cout,
//       ovf <= (a[W-1]==b_eff[W-1]) && (final sum MSB != a[W-1]), out_valid <= 1, go to DONE.
//     DONE: in_ready=0. sum/cout/ovf held stable. On out_valid&&out_ready: out_valid <= 0, go to IDLE.
//   - Latency: accept at edge E, out_valid is high after edge E+NIBBLES (WIDTH=16 -> E+4).
//     Peak throughput is one op per NIBBLES+2 cycles when out_ready is held high.
//   - in_ready and out_valid are never high in the same cycle; there is no accept/retire bypass.
//   - Operands are sampled only at acceptance; changes to a/b/cin/sub during RUN/DONE are ignored.
//   - sum is meaningful only while out_valid=1 (partially updated during RUN). It keeps its last
//     value through IDLE until the next acceptance.
//   - Arithmetic is modulo 2^WIDTH, and the carry chain between nibbles is exact: the result equals
//     {cout,sum} = a + b_eff + carry_init.
//   - out_ready held low: stays in DONE indefinitely; in_valid is ignored (in_ready=0).
// STRUCTURE
//   - Shared package: FSM state enum (IDLE/RUN/DONE, 2-bit encoding) and NIBBLE_W=4 localparam.
//   - One sub-module: cla4_slice (4-bit generate/propagate lookahead adder: a,b,cin -> sum[3:0],cout),
//     instantiated once. Controller holds the FSM, index counter, carry register and operand/result regs.
// TESTING
//   - Reset: assert rst_n=0 mid-RUN -> in_ready=1, out_valid=0, sum=0 immediately; the next op is correct.
//   - Add, WIDTH=16: a=16'h00FF, b=16'h0001, cin=0 -> after 4 cycles sum=16'h0100, cout=0, ovf=0.
//   - Carry ripple: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0.
//   - Subtract: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0;
//     sub=1, a=16'h8000, b=16'h0001 -> sum=16'h7FFF, ovf=1.
//   - Backpressure: out_ready=0 for 10 cycles -> out_valid and sum stable, in_ready=0, in_valid ignored;
//     out_ready=1 -> IDLE next cycle.
//   - Random back-to-back ops with random out_ready, WIDTH in {4,16,32}: every result matches the
//     reference model, and the accept-to-valid latency is exactly NIBBLES cycles.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types for the nibble-serial adder controller: FSM state encoding and slice width.
package nibble_serial_adder_ctrl_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/nibble_serial_adder_ctrl_cla4_slice.sv
// 4-bit carry-lookahead adder slice; all carries are formed directly from generate/propagate terms.
module cla4_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds or subtracts WIDTH-bit operands one nibble per clock through a single shared CLA slice.
//   state   | meaning
//   IDLE    | in_ready=1, waiting for an operand set
//   RUN     | one nibble per edge, LSB first, carry held between nibbles
//   DONE    | out_valid=1, result held until out_ready
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [CNT_W+1:0] w_ofs;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;

  assign w_ofs = {r_idx, 2'b00};

  cla4_slice u_slice (
    .i_a    (r_a[w_ofs +: NIBBLE_W]),
    .i_b    (r_b[w_ofs +: NIBBLE_W]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= sub ? ~b : b;
            r_carry    <= sub ? 1'b1 : cin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[w_ofs +: NIBBLE_W] <= w_slice_sum;
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_cout      <= w_slice_cout;
            // overflow: like-signed operands producing an opposite-signed result
            r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_slice_sum[3] != r_a[WIDTH-1]);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl at WIDTH 4, 16 and 32 with a scoreboard-based reference model.
module tb_nibble_serial_adder_ctrl;
  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        in_valid, cin, sub, out_ready;
  logic [31:0] a, b;

  logic        ir4, ov4, co4, of4;
  logic [3:0]  s4;
  logic        ir16, ov16, co16, of16;
  logic [15:0] s16;
  logic        ir32, ov32, co32, of32;
  logic [31:0] s32;

  logic        m_in_ready, m_out_valid, m_cout, m_ovf;
  logic [31:0] m_sum;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2'd0), .in_ready(ir4),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(out_ready),
    .sum(s4), .cout(co4), .ovf(of4));

  nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2'd1), .in_ready(ir16),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready),
    .sum(s16), .cout(co16), .ovf(of16));

  nibble_serial_adder_ctrl #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2'd2), .in_ready(ir32),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready),
    .sum(s32), .cout(co32), .ovf(of32));

  always_comb begin
    m_in_ready = ir16; m_out_valid = ov16; m_sum = 32'(s16); m_cout = co16; m_ovf = of16;
    case (sel)
      2'd0: begin m_in_ready = ir4; m_out_valid = ov4; m_sum = 32'(s4); m_cout = co4; m_ovf = of4; end
      2'd2: begin m_in_ready = ir32; m_out_valid = ov32; m_sum = s32; m_cout = co32; m_ovf = of32; end
      default: ;
    endcase
  end

  function automatic int width_of(input logic [1:0] s);
    return (s == 2'd0) ? 4 : (s == 2'd2) ? 32 : 16;
  endfunction

  function automatic exp_t model(input int w, input logic [31:0] ta, input logic [31:0] tb_,
                                 input logic tcin, input logic tsub);
    exp_t        e;
    logic [31:0] mask, am, beff;
    logic [32:0] full;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am   = ta & mask;
    beff = (tsub ? ~tb_ : tb_) & mask;
    full = {1'b0, am} + {1'b0, beff} + 33'(tsub ? 1'b1 : tcin);
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    e.ovf  = (am[w-1] == beff[w-1]) && (e.sum[w-1] != am[w-1]);
    return e;
  endfunction

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin,
                       input logic tsub, input string name);
    int   nib, k, lat;
    exp_t e;
    nib = width_of(sel) / 4;
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    while (!m_in_ready && k < 50) begin @(negedge clk); k++; end
    n_tests++;
    if (!m_in_ready) begin
      n_fail++; $display("FAIL %s accept timeout: in_ready=%b required 1", name, m_in_ready);
      in_valid = 1'b0; return;
    end
    sb.push_back(model(width_of(sel), ta, tb_, tcin, tsub));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!m_out_valid && lat < 100) begin @(negedge clk); lat++; end
    n_tests++;
    if (lat !== nib) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", name, lat, nib); end
    e = sb.pop_front();
    n_tests++;
    if (m_sum !== e.sum) begin n_fail++; $display("FAIL %s sum: got %h required %h", name, m_sum, e.sum); end
    n_tests++;
    if (m_cout !== e.cout) begin n_fail++; $display("FAIL %s cout: got %b required %b", name, m_cout, e.cout); end
    n_tests++;
    if (m_ovf !== e.ovf) begin n_fail++; $display("FAIL %s ovf: got %b required %b", name, m_ovf, e.ovf); end
    @(negedge clk);
    n_tests++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s retire: in_ready=%b out_valid=%b required 1/0", name, m_in_ready, m_out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 2'd1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #23;
    n_tests++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_sum !== 32'h0 || m_cout !== 1'b0 || m_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ir=%b ov=%b sum=%h cout=%b ovf=%b required 1 0 0 0 0",
               m_in_ready, m_out_valid, m_sum, m_cout, m_ovf);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    sel = 2'd1;
    do_op(32'h00FF, 32'h0001, 1'b0, 1'b0, "add_00ff_0001");
    do_op(32'hFFFF, 32'h0000, 1'b1, 1'b0, "carry_ripple");
    do_op(32'h7FFF, 32'h0001, 1'b0, 1'b0, "add_pos_ovf");
  endtask

  task automatic test_sub();
    sel = 2'd1;
    do_op(32'h0005, 32'h0007, 1'b0, 1'b1, "sub_5_7");
    do_op(32'h0005, 32'h0007, 1'b1, 1'b1, "sub_cin_ignored");
    do_op(32'h8000, 32'h0001, 1'b0, 1'b1, "sub_neg_ovf");
    do_op(32'h1234, 32'h1234, 1'b0, 1'b1, "sub_equal");
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   k;
    sel = 2'd1;
    @(negedge clk);
    a = 32'h3A5C; b = 32'h1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    sb.push_back(model(16, 32'h3A5C, 32'h1111, 1'b1, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!m_out_valid && k < 100) begin @(negedge clk); k++; end
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 32'($urandom); b = 32'($urandom);
      @(negedge clk);
      n_tests++;
      if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 || m_sum !== e.sum) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: ov=%b ir=%b sum=%h required 1 0 %h",
                 i, m_out_valid, m_in_ready, m_sum, e.sum);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release: ir=%b ov=%b required 1 0", m_in_ready, m_out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    sel = 2'd1;
    @(negedge clk);
    a = 32'h1234; b = 32'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_sum !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_run: ir=%b ov=%b sum=%h required 1 0 0", m_in_ready, m_out_valid, m_sum);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(32'hABCD, 32'h1357, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back(input logic [1:0] s);
    int   w, nib, cyc, acc_cyc, issued, retired;
    logic pending, acc_flag, prev_ov, ir, ov;
    exp_t e;
    sel = s; w = width_of(s); nib = w / 4;
    in_valid = 1'b0; out_ready = 1'b0;
    pending = 1'b0; acc_flag = 1'b0; prev_ov = 1'b0;
    cyc = 0; acc_cyc = 0; issued = 0; retired = 0;
    while (retired < 40 && cyc < 4000) begin
      @(negedge clk); cyc++;
      ir = m_in_ready; ov = m_out_valid;
      n_tests++;
      if (ir && ov) begin n_fail++; $display("FAIL b2b_w%0d ready_valid_overlap at cycle %0d", w, cyc); end
      if (acc_flag) begin in_valid = 1'b0; pending = 1'b0; acc_flag = 1'b0; end
      if (ov && !prev_ov) begin
        n_tests++;
        if (cyc - acc_cyc - 1 != nib) begin
          n_fail++; $display("FAIL b2b_w%0d latency: got %0d required %0d", w, cyc - acc_cyc - 1, nib);
        end
      end
      prev_ov = ov;
      if (!pending && issued < 40 && $urandom_range(0, 3) != 0) begin
        a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        b = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1; pending = 1'b1; issued++;
      end else if (!pending) begin
        a = 32'($urandom); sub = 1'($urandom_range(0, 1));
      end
      if (pending && ir) begin
        sb.push_back(model(w, a, b, cin, sub));
        acc_cyc = cyc; acc_flag = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (ov && out_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_w%0d unexpected result sum=%h", w, m_sum);
        end else begin
          e = sb.pop_front();
          if (m_sum !== e.sum || m_cout !== e.cout || m_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL b2b_w%0d result: sum=%h cout=%b ovf=%b required %h %b %b",
                     w, m_sum, m_cout, m_ovf, e.sum, e.cout, e.ovf);
          end
        end
        retired++;
      end
    end
    n_tests++;
    if (retired < 40) begin n_fail++; $display("FAIL b2b_w%0d timeout: retired %0d required 40", w, retired); end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    repeat (nib + 3) @(negedge clk);
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back(2'd0);
    test_back_to_back(2'd1);
    test_back_to_back(2'd2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
